fetch_queue_unit: RTL and testbench

//  Parametrised multi-wide fetch stage with a decoupling instruction queue; successor to the single-word Fetch.

---
 rtl/fetch_queue_unit.sv | 74 +++++++
 tb/tb_fetch_queue_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: multi-wide instruction fetch feeding a FIFO queue with valid/ready output to Decode
module fetch_queue_unit #(
    parameter int          ROM_WORDS   = 256,
    parameter int          FETCH_WIDTH = 2,
    parameter int          QUEUE_DEPTH = 8,
    parameter logic [31:0] PC_RESET    = 32'h0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [ROM_WORDS*32-1:0]            instr_rom,
    input  logic [31:0]                        rom_size,
    input  logic                               redirect_valid,
    input  logic [31:0]                        redirect_pc,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [31:0]                        out_instr,
    output logic [31:0]                        out_pc,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count,
    output logic                               fetch_complete
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH+1);
    localparam int RW = ROM_WORDS > 1 ? $clog2(ROM_WORDS) : 1;
    logic [31:0]   rom_w   [ROM_WORDS];
    logic [31:0]   q_instr [QUEUE_DEPTH];
    logic [31:0]   q_pc    [QUEUE_DEPTH];
    logic [31:0]   pc, words_left, rom_left, lim, n;
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          done, deq;
    for (genvar g = 0; g < ROM_WORDS; g++) begin : g_rom
        assign rom_w[g] = instr_rom[g*32 +: 32];
    end
    assign done        = pc >= rom_size || pc >= 32'(ROM_WORDS*4);
    assign words_left  = (rom_size - pc) >> 2;
    assign rom_left    = 32'(ROM_WORDS) - (pc >> 2);
    assign lim         = words_left < 32'(FETCH_WIDTH) ? words_left : 32'(FETCH_WIDTH);
    // Room is judged on the start-of-cycle count; a same-cycle dequeue does not help.
    assign n           = (done || count > CW'(QUEUE_DEPTH-FETCH_WIDTH)) ? '0 : (rom_left < lim ? rom_left : lim);
    assign out_valid   = count != '0;
    assign deq         = out_valid && out_ready;
    assign out_instr   = out_valid ? q_instr[head] : '0;
    assign out_pc      = out_valid ? q_pc[head] : '0;
    assign queue_count = count;
    assign fetch_complete = done && count == '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc    <= PC_RESET;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            pc    <= redirect_pc & ~32'h3;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (n > 32'(i)) begin
                    q_instr[tail + AW'(i)] <= rom_w[RW'((pc >> 2) + 32'(i))];
                    q_pc[tail + AW'(i)]    <= pc + 32'(4*i);
                end
            end
            tail  <= tail + AW'(n);
            pc    <= pc + (n << 2);
            head  <= head + AW'(deq);
            count <= count + CW'(n) - CW'(deq);
        end
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed scenarios plus randomized run against a queue-based reference model
module tb_fetch_queue_unit;
    localparam int RW = 256;
    localparam int FW = 2;
    localparam int QD = 8;
    logic              clk = 0;
    logic              reset = 0;
    logic [RW*32-1:0]  instr_rom;
    logic [31:0]       rom_size = 0;
    logic              redirect_valid = 0;
    logic [31:0]       redirect_pc = 0;
    logic              out_valid;
    logic              out_ready = 0;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic [3:0]        queue_count;
    logic              fetch_complete;
    int total = 0;
    int bad = 0;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    ent_t        m_q[$];
    logic [31:0] m_pc;

    fetch_queue_unit #(.ROM_WORDS(RW), .FETCH_WIDTH(FW), .QUEUE_DEPTH(QD), .PC_RESET(32'h0)) dut (
        .clk(clk), .reset(reset), .instr_rom(instr_rom), .rom_size(rom_size),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .queue_count(queue_count), .fetch_complete(fetch_complete)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] k);
        return instr_rom[k*32 +: 32];
    endfunction

    task automatic model_step();
        int n;
        logic [31:0] wl, rl;
        if (redirect_valid) begin
            m_q.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
            return;
        end
        n = 0;
        if (m_pc < rom_size && m_pc < RW*4 && m_q.size() <= QD-FW) begin
            wl = (rom_size - m_pc) / 4;
            rl = RW - m_pc / 4;
            n = FW;
            if (wl < n) n = int'(wl);
            if (rl < n) n = int'(rl);
        end
        if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
        for (int i = 0; i < n; i++) m_q.push_back('{rom_word(m_pc/4 + i), m_pc + 4*i});
        m_pc += 4*n;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        reset = 0;
        m_q.delete();
        m_pc = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
    endtask

    task automatic test_reset();
        rom_size = 64;
        out_ready = 0;
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        total += 4;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        if (queue_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", queue_count); end
        if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
        if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
        apply_reset();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL release_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_stream();
        out_ready = 1;
        rom_size = 20;
        apply_reset();
        for (int k = 1; k <= 6; k++) begin
            tick();
            total++;
            if (k == 6) begin
                if (fetch_complete !== 1'b1) begin bad++; $display("FAIL stream_complete got=%b exp=1", fetch_complete); end
            end else if (out_valid !== 1'b1 || out_pc !== 32'(4*(k-1))) begin
                bad++;
                $display("FAIL stream_pc cycle=%0d got v=%b pc=%0d exp v=1 pc=%0d", k, out_valid, out_pc, 4*(k-1));
            end
        end
    endtask

    task automatic test_backpressure();
        int got[$];
        out_ready = 0;
        rom_size = 64;
        apply_reset();
        for (int i = 1; i <= 6; i++) begin
            tick();
            total++;
            if (queue_count !== 4'((2*i > 8) ? 8 : 2*i)) begin
                bad++;
                $display("FAIL bp_count step=%0d got=%0d exp=%0d", i, queue_count, (2*i > 8) ? 8 : 2*i);
            end
        end
        out_ready = 1;
        for (int t = 0; t < 40; t++) begin
            if (out_valid) got.push_back(int'(out_pc));
            tick();
            if (fetch_complete) break;
        end
        total++;
        if (got.size() != 16) begin bad++; $display("FAIL bp_drain_len got=%0d exp=16", got.size()); end
        for (int j = 0; j < got.size() && j < 16; j++) begin
            total++;
            if (got[j] != 4*j) begin bad++; $display("FAIL bp_drain_pc idx=%0d got=%0d exp=%0d", j, got[j], 4*j); end
        end
    endtask

    task automatic test_redirect();
        out_ready = 0;
        rom_size = 64;
        apply_reset();
        tick();
        tick();
        out_ready = 1;
        tick();
        total++;
        if (queue_count !== 4'd5) begin bad++; $display("FAIL redir_setup got=%0d exp=5", queue_count); end
        out_ready = 0;
        redirect_valid = 1;
        redirect_pc = 32'h0E;
        tick();
        redirect_valid = 0;
        total++;
        if (queue_count !== 4'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL redir_flush got cnt=%0d v=%b exp cnt=0 v=0", queue_count, out_valid);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0C) begin
            bad++;
            $display("FAIL redir_target got v=%b pc=%h exp v=1 pc=0000000c", out_valid, out_pc);
        end
        redirect_valid = 1;
        redirect_pc = 32'd100;
        tick();
        redirect_valid = 0;
        total++;
        if (fetch_complete !== 1'b1) begin bad++; $display("FAIL redir_past_end got=%b exp=1", fetch_complete); end
    endtask

    task automatic test_short();
        int mx = 0;
        int last = -1;
        out_ready = 0;
        rom_size = 12;
        apply_reset();
        for (int t = 0; t < 4; t++) begin
            tick();
            if (int'(queue_count) > mx) mx = int'(queue_count);
        end
        out_ready = 1;
        for (int t = 0; t < 8; t++) begin
            if (out_valid) last = int'(out_pc);
            tick();
            if (int'(queue_count) > mx) mx = int'(queue_count);
        end
        total += 3;
        if (mx != 3) begin bad++; $display("FAIL short_max got=%0d exp=3", mx); end
        if (last != 8) begin bad++; $display("FAIL short_last got=%0d exp=8", last); end
        if (fetch_complete !== 1'b1) begin bad++; $display("FAIL short_complete got=%b exp=1", fetch_complete); end
    endtask

    task automatic test_async_reset();
        out_ready = 1;
        rom_size = 64;
        apply_reset();
        repeat (3) tick();
        #2;
        reset = 0;
        m_q.delete();
        m_pc = 0;
        #1;
        total++;
        if (out_valid !== 1'b0 || queue_count !== 4'd0 || out_pc !== 32'h0) begin
            bad++;
            $display("FAIL async_reset got v=%b cnt=%0d pc=%h exp 0 0 0", out_valid, queue_count, out_pc);
        end
        @(posedge clk);
        #1;
        reset = 1;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            bad++;
            $display("FAIL async_restart got v=%b pc=%h exp v=1 pc=0", out_valid, out_pc);
        end
    endtask

    task automatic test_full_boundary();
        out_ready = 0;
        rom_size = 64;
        apply_reset();
        repeat (3) tick();
        out_ready = 1;
        tick();
        total++;
        if (queue_count !== 4'(QD-1)) begin bad++; $display("FAIL full_enq_deq got=%0d exp=%0d", queue_count, QD-1); end
        tick();
        total++;
        if (queue_count !== 4'(QD-2)) begin bad++; $display("FAIL full_no_fetch got=%0d exp=%0d", queue_count, QD-2); end
    endtask

    task automatic test_random();
        logic ev, efc;
        logic [31:0] epc, ein;
        out_ready = 1;
        rom_size = 1100;
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            out_ready = $urandom_range(0, 3) != 0;
            redirect_valid = $urandom_range(0, 19) == 0;
            redirect_pc = $urandom_range(0, 1100);
            if ($urandom_range(0, 15) == 0) rom_size = 4 * $urandom_range(0, 275);
            tick();
            ev  = m_q.size() != 0;
            epc = ev ? m_q[0].pc : 32'h0;
            ein = ev ? m_q[0].instr : 32'h0;
            efc = (m_pc >= rom_size || m_pc >= RW*4) && m_q.size() == 0;
            total++;
            if (out_valid !== ev || out_pc !== epc || out_instr !== ein || queue_count !== 4'(m_q.size()) || fetch_complete !== efc) begin
                bad++;
                $display("FAIL random c=%0d got v=%b pc=%h in=%h cnt=%0d fc=%b exp v=%b pc=%h in=%h cnt=%0d fc=%b",
                         c, out_valid, out_pc, out_instr, queue_count, fetch_complete, ev, epc, ein, m_q.size(), efc);
            end
        end
        redirect_valid = 0;
    endtask

    initial begin
        for (int i = 0; i < RW; i++) instr_rom[i*32 +: 32] = $urandom;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_short();
        test_async_reset();
        test_full_boundary();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
